// File: rtl/bsg_link_upstream_rr_arbiter.sv
// Packet-atomic round-robin arbiter feeding one bsg_link_ddr_upstream core port.
// Flits are tagged with the source index and pass through a 2-entry output buffer.
module bsg_link_upstream_rr_arbiter #(
    parameter int num_in_p = 4,
    parameter int width_p  = 32,
    localparam int id_width_lp   = (num_in_p > 1) ? $clog2(num_in_p) : 1,
    localparam int link_width_lp = width_p + id_width_lp
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [num_in_p-1:0][width_p-1:0]   data_i,
    input  logic [num_in_p-1:0]                valid_i,
    input  logic [num_in_p-1:0]                last_i,
    output logic [num_in_p-1:0]                ready_o,
    output logic [link_width_lp-1:0]           link_data_o,
    output logic                               link_last_o,
    output logic                               link_valid_o,
    input  logic                               link_ready_i,
    output logic [id_width_lp-1:0]             owner_o,
    output logic                               locked_o
);

    localparam int entry_width_lp = link_width_lp + 1;
    localparam logic [id_width_lp-1:0] last_id_lp = id_width_lp'(num_in_p - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [id_width_lp-1:0] rr_ptr_q, rr_ptr_d;
    logic [id_width_lp-1:0] owner_q, owner_d;

    logic [entry_width_lp-1:0] mem_q [2];
    logic                      wr_ptr_q, rd_ptr_q;
    logic [1:0]                count_q, count_d;
    logic                      full, empty;

    logic [id_width_lp-1:0] winner;
    logic                   any_valid;
    logic [id_width_lp-1:0] sel_id;
    logic                   grant_valid;
    logic                   accept;
    logic                   acc_last;
    logic [width_p-1:0]     acc_data;
    logic                   deq;
    int                     idx;

    assign full  = count_q[1];
    assign empty = (count_q == 2'd0);

    // Scan from the highest offset down so the lowest offset past rr_ptr wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int i = num_in_p - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= num_in_p) idx = idx - num_in_p;
            if (valid_i[idx]) begin
                winner    = id_width_lp'(idx);
                any_valid = 1'b1;
            end
        end
    end

    assign sel_id      = (state_q == LOCK) ? owner_q : winner;
    assign grant_valid = (state_q == LOCK) | any_valid;

    for (genvar gi = 0; gi < num_in_p; gi++) begin : g_ready
        assign ready_o[gi] = ~reset_i & grant_valid & ~full & (sel_id == id_width_lp'(gi));
    end

    assign accept   = |(valid_i & ready_o);
    assign acc_last = last_i[sel_id];
    assign acc_data = data_i[sel_id];
    assign deq      = ~empty & link_ready_i;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        if (accept) begin
            if (state_q == IDLE) begin
                owner_d  = winner;
                rr_ptr_d = (winner == last_id_lp) ? '0 : winner + 1'b1;
                if (!acc_last) state_d = LOCK;
            end else if (acc_last) begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({accept, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            count_q  <= count_d;
            if (accept) wr_ptr_q <= ~wr_ptr_q;
            if (deq)    rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (accept) mem_q[wr_ptr_q] <= {sel_id, acc_last, acc_data};
    end

    assign link_valid_o = ~empty;
    assign link_data_o  = {mem_q[rd_ptr_q][entry_width_lp-1 -: id_width_lp],
                           mem_q[rd_ptr_q][width_p-1:0]};
    assign link_last_o  = mem_q[rd_ptr_q][width_p];
    assign owner_o      = owner_q;
    assign locked_o     = (state_q == LOCK);

    // A stalled owner must keep its flit steady until it is taken.
    logic               chk_pending_q;
    logic [width_p-1:0] chk_data_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            chk_pending_q <= 1'b0;
            chk_data_q    <= '0;
        end else begin
            chk_pending_q <= (state_q == LOCK) & valid_i[owner_q] & ~ready_o[owner_q];
            chk_data_q    <= data_i[owner_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && chk_pending_q) begin
            assert (valid_i[owner_q] && (data_i[owner_q] == chk_data_q));
        end
    end

endmodule

// File: tb/tb_bsg_link_upstream_rr_arbiter.sv
// Directed bench for the round-robin link arbiter: vector table plus packet scenarios.
module tb_bsg_link_upstream_rr_arbiter;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic [3:0][31:0] data_i;
    logic [3:0]       valid_i;
    logic [3:0]       last_i;
    logic [3:0]       ready_o;
    logic [33:0]      link_data_o;
    logic             link_last_o;
    logic             link_valid_o;
    logic             link_ready_i;
    logic [1:0]       owner_o;
    logic             locked_o;

    bsg_link_upstream_rr_arbiter #(.num_in_p(4), .width_p(32)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
        .last_i(last_i), .ready_o(ready_o), .link_data_o(link_data_o),
        .link_last_o(link_last_o), .link_valid_o(link_valid_o),
        .link_ready_i(link_ready_i), .owner_o(owner_o), .locked_o(locked_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] valid;
        logic       lr;
        logic [3:0] exp_rdy;
        logic       exp_lv;
        logic [1:0] exp_tag;
    } vec_t;

    vec_t tbl [17];
    int checks = 0;
    int errors = 0;

    // Requester model: per-source packet length, flit quota and progress.
    int en [4], len [4], quota [4], sent [4], pos [4], rx_seq [4];
    int rx_total, acc_total, prev_tag;
    bit open_pkt;
    int q_tags [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            valid_i[k] = (en[k] != 0) && (sent[k] < quota[k]);
            data_i[k]  = {8'(k), 24'(sent[k])};
            last_i[k]  = (pos[k] == len[k] - 1);
        end
    endtask

    task automatic observe(input logic [33:0] ld, input logic ll);
        int tag;
        tag = int'(ld[33:32]);
        chk("tag_src", 64'(ld[31:24]), 64'(tag));
        chk("seq", 64'(ld[23:0]), 64'(rx_seq[tag]));
        chk("last", 64'(ll), 64'((rx_seq[tag] % len[tag]) == len[tag] - 1));
        if (open_pkt) chk("contig", 64'(tag), 64'(prev_tag));
        $display("flit tag=%0d seq=%0d last=%0b", tag, ld[23:0], ll);
        open_pkt = !ll;
        prev_tag = tag;
        rx_seq[tag]++;
        rx_total++;
        q_tags.push_back(tag);
    endtask

    task automatic pre();
        drive();
        #1;
    endtask

    task automatic post();
        logic [3:0]  acc;
        logic        lv, ll;
        logic [33:0] ld;
        acc = valid_i & ready_o;
        lv  = link_valid_o & link_ready_i;
        ld  = link_data_o;
        ll  = link_last_o;
        @(posedge clk_i);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (acc[k]) begin
                sent[k]++;
                acc_total++;
                pos[k] = last_i[k] ? 0 : pos[k] + 1;
            end
        end
        if (lv) observe(ld, ll);
    endtask

    task automatic tick();
        pre();
        post();
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            en[k] = 0; len[k] = 1; quota[k] = 0; sent[k] = 0; pos[k] = 0; rx_seq[k] = 0;
        end
        rx_total = 0; acc_total = 0; open_pkt = 0; prev_tag = 0;
        q_tags.delete();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        clear_model();
        link_ready_i = 1'b1;
        drive();
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    task automatic drain(input string name, input int total);
        int n = 0;
        link_ready_i = 1'b1;
        while (rx_total < total && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_drain"}, 64'(rx_total), 64'(total));
    endtask

    initial begin
        int exp_lock [6];
        int exp_bub [5];

        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
        tbl[2]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd1};
        tbl[3]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd2};
        tbl[4]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
        tbl[5]  = '{4'b1000, 1'b1, 4'b1000, 1'b0, 2'd0};
        tbl[6]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd3};
        tbl[7]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd0};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1};
        tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[10] = '{4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0};
        tbl[11] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd0};
        tbl[12] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd0};
        tbl[13] = '{4'b0100, 1'b1, 4'b0000, 1'b1, 2'd0};
        tbl[14] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd1};
        tbl[15] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2};
        tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

        // Reset with every requester asking
        reset_i = 1'b1;
        link_ready_i = 1'b1;
        valid_i = 4'hF;
        last_i  = 4'hF;
        for (int k = 0; k < 4; k++) data_i[k] = 32'hD0 + k;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_link_valid", 64'(link_valid_o), 64'd0);
        chk("rst_locked", 64'(locked_o), 64'd0);
        chk("rst_owner", 64'(owner_o), 64'd0);
        reset_i = 1'b0;

        // Single-flit vector table
        for (int i = 0; i < 17; i++) begin
            valid_i = tbl[i].valid;
            link_ready_i = tbl[i].lr;
            #1;
            $display("vec %0d valid=%b ready=%b link_valid=%b tag=%0d", i, valid_i, ready_o,
                     link_valid_o, link_data_o[33:32]);
            chk($sformatf("vec%0d_ready", i), 64'(ready_o), 64'(tbl[i].exp_rdy));
            chk($sformatf("vec%0d_link_valid", i), 64'(link_valid_o), 64'(tbl[i].exp_lv));
            if (tbl[i].exp_lv)
                chk($sformatf("vec%0d_link_data", i), 64'(link_data_o),
                    64'({tbl[i].exp_tag, 32'hD0 + 32'(tbl[i].exp_tag)}));
            @(posedge clk_i);
            #1;
        end

        // Lock: requester 2 sends 3 flits while 0,1,3 wait
        do_reset();
        en[2] = 1; len[2] = 3; quota[2] = 3;
        tick();
        en[0] = 1; quota[0] = 1; en[1] = 1; quota[1] = 1; en[3] = 1; quota[3] = 1;
        for (int c = 0; c < 2; c++) begin
            pre();
            chk("lock_locked", 64'(locked_o), 64'd1);
            chk("lock_others_ready", 64'(ready_o & 4'b1011), 64'd0);
            post();
        end
        drain("lock", 6);
        exp_lock = '{2, 2, 2, 3, 0, 1};
        chk("lock_order_len", 64'(q_tags.size()), 64'd6);
        for (int i = 0; i < 6 && i < q_tags.size(); i++)
            chk($sformatf("lock_order%0d", i), 64'(q_tags[i]), 64'(exp_lock[i]));

        // Owner bubble: requester 1 goes idle mid-packet
        do_reset();
        en[1] = 1; len[1] = 4; quota[1] = 4;
        tick();
        en[0] = 1; quota[0] = 1;
        tick();
        en[1] = 0;
        for (int c = 0; c < 2; c++) begin
            pre();
            chk("bubble_ready", 64'(ready_o), 64'b0010);
            chk("bubble_locked", 64'(locked_o), 64'd1);
            post();
        end
        en[1] = 1;
        drain("bubble", 5);
        exp_bub = '{1, 1, 1, 1, 0};
        chk("bubble_order_len", 64'(q_tags.size()), 64'd5);
        for (int i = 0; i < 5 && i < q_tags.size(); i++)
            chk($sformatf("bubble_order%0d", i), 64'(q_tags[i]), 64'(exp_bub[i]));

        // Backpressure under full load
        do_reset();
        for (int k = 0; k < 4; k++) begin
            en[k] = 1; len[k] = 2; quota[k] = 6;
        end
        link_ready_i = 1'b0;
        repeat (5) tick();
        pre();
        chk("bp_accepted", 64'(acc_total), 64'd2);
        chk("bp_ready", 64'(ready_o), 64'd0);
        chk("bp_link_valid", 64'(link_valid_o), 64'd1);
        link_ready_i = 1'b1;
        post();
        drain("bp", 24);
        for (int k = 0; k < 4; k++)
            chk($sformatf("bp_count%0d", k), 64'(rx_seq[k]), 64'd6);

        // Reset in the middle of a 4-flit packet from requester 3
        do_reset();
        link_ready_i = 1'b0;
        en[3] = 1; len[3] = 4; quota[3] = 4;
        tick();
        tick();
        pre();
        chk("mid_sent", 64'(sent[3]), 64'd2);
        chk("mid_locked_before", 64'(locked_o), 64'd1);
        reset_i = 1'b1;
        #1;
        chk("mid_link_valid", 64'(link_valid_o), 64'd0);
        chk("mid_locked", 64'(locked_o), 64'd0);
        chk("mid_owner", 64'(owner_o), 64'd0);
        chk("mid_ready", 64'(ready_o), 64'd0);
        clear_model();
        for (int k = 0; k < 4; k++) begin
            en[k] = 1; quota[k] = 1;
        end
        link_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        pre();
        chk("mid_rr_ptr", 64'(ready_o), 64'b0001);
        post();
        drain("mid", 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
